display_frame_receiver: RTL and testbench



---
 rtl/display_frame_receiver_pkg.sv | 24 ++
 rtl/display_frame_receiver_if.sv | 14 +
 rtl/display_frame_receiver_rise_detect.sv | 21 ++
 rtl/display_frame_receiver.sv | 116 +++++++++++
 tb/tb_display_frame_receiver.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/display_frame_receiver_pkg.sv
`default_nettype none
// ============================================================================
// display_frame_receiver_pkg : shared frame constants, state codes, helpers
// Rev 1.0
// ============================================================================
package display_frame_receiver_pkg;

    localparam int DEF_DIGITS         = 6;
    localparam int DEF_BITS_PER_DIGIT = 8;
    localparam int DEF_FRAME_BITS     = DEF_DIGITS * DEF_BITS_PER_DIGIT;

    localparam int                 CNT_W   = 6;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;

    localparam int                 STATE_W   = 1;
    localparam logic [STATE_W-1:0] WAIT_SYNC = 1'b0;
    localparam logic [STATE_W-1:0] RECEIVE   = 1'b1;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/display_frame_receiver_if.sv
`default_nettype none
// ============================================================================
// display_frame_receiver_if : serial display link (data, shift clock, latch)
// Rev 1.0
// ============================================================================
interface display_frame_receiver_if;
    logic serial_in;
    logic ext_clk;
    logic ext_latch;

    modport master (output serial_in, output ext_clk, output ext_latch);
    modport slave  (input  serial_in, input  ext_clk, input  ext_latch);
endinterface
`default_nettype wire

// File: rtl/display_frame_receiver_rise_detect.sv
`default_nettype none
// ============================================================================
// rise_detect : free-running 1-bit delay register with rising-edge output
// Rev 1.0
// ============================================================================
module rise_detect (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic d_i,
    output logic      rise_o
);
    logic d_q;

    always_ff @(posedge clk) begin
        if (reset) d_q <= 1'b0;
        else       d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;
endmodule
`default_nettype wire

// File: rtl/display_frame_receiver.sv
`default_nettype none
// ============================================================================
// display_frame_receiver : deserializes the display stream into digit bytes
// Rev 1.0
// ============================================================================
module display_frame_receiver
    import display_frame_receiver_pkg::*;
#(
    parameter int DIGITS         = DEF_DIGITS,
    parameter int BITS_PER_DIGIT = DEF_BITS_PER_DIGIT
) (
    input  wire logic                               clk,
    input  wire logic                               reset,
    input  wire logic                               en,
    display_frame_receiver_if.slave                 link,
    output logic [DIGITS*BITS_PER_DIGIT-1:0]        frame_data,
    output logic                                    frame_valid,
    output logic                                    frame_error,
    output logic [7:0]                              frame_count,
    output logic                                    synced
);
    localparam int               FRAME_BITS = DIGITS * BITS_PER_DIGIT;
    localparam logic [CNT_W-1:0] FRAME_CNT  = CNT_W'(FRAME_BITS);

    logic clk_rise;
    logic latch_rise;

    // Edge registers run even while disabled so re-enabling never fakes an edge.
    rise_detect u_clk_rise (
        .clk    (clk),
        .reset  (reset),
        .d_i    (link.ext_clk),
        .rise_o (clk_rise)
    );

    rise_detect u_latch_rise (
        .clk    (clk),
        .reset  (reset),
        .d_i    (link.ext_latch),
        .rise_o (latch_rise)
    );

    logic [STATE_W-1:0]    state_q,       state_d;
    logic [FRAME_BITS-1:0] shift_q,       shift_d;
    logic [CNT_W-1:0]      cnt_q,         cnt_d;
    logic [FRAME_BITS-1:0] frame_data_q,  frame_data_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_error_q, frame_error_d;
    logic [7:0]            frame_count_q, frame_count_d;
    logic                  synced_q,      synced_d;

    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        cnt_d         = cnt_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_error_d = frame_error_q;
        frame_count_d = frame_count_q;
        synced_d      = synced_q;

        if (en) begin
            if (clk_rise) begin
                shift_d = {shift_q[FRAME_BITS-2:0], link.serial_in};
                cnt_d   = sat_inc(cnt_q);
            end
            // A bit shifted this cycle is already in shift_d/cnt_d when publishing.
            if (latch_rise) begin
                case (state_q)
                    WAIT_SYNC: begin
                        shift_d  = '0;
                        cnt_d    = '0;
                        synced_d = 1'b1;
                        state_d  = RECEIVE;
                    end
                    default: begin
                        frame_data_d  = shift_d;
                        frame_error_d = (cnt_d != FRAME_CNT);
                        frame_valid_d = 1'b1;
                        frame_count_d = frame_count_q + 8'd1;
                        cnt_d         = '0;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_SYNC;
            shift_q       <= '0;
            cnt_q         <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            frame_count_q <= 8'd0;
            synced_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            cnt_q         <= cnt_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            frame_count_q <= frame_count_d;
            synced_q      <= synced_d;
        end
    end

    assign frame_data  = frame_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_error = frame_error_q;
    assign frame_count = frame_count_q;
    assign synced      = synced_q;
endmodule
`default_nettype wire

// File: tb/tb_display_frame_receiver.sv
`default_nettype none
// ============================================================================
// tb_display_frame_receiver : random-stimulus bench against a bit-history model
// Rev 1.0
// ============================================================================
module tb_display_frame_receiver;
    localparam int FB = 48;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [47:0] frame_data;
    logic        frame_valid;
    logic        frame_error;
    logic [7:0]  frame_count;
    logic        synced;

    display_frame_receiver_if link ();

    display_frame_receiver dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .link        (link.slave),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_error (frame_error),
        .frame_count (frame_count),
        .synced      (synced)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int valid_seen = 0;

    // Reference model: bits seen since sync, count of edges since the last latch.
    bit          m_bits[$];
    int          m_cnt;
    bit          m_synced;
    bit          m_prev_ck, m_prev_lt;
    logic [47:0] m_data;
    bit          m_valid, m_error;
    int          m_count;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [47:0] model_frame();
        logic [47:0] f = '0;
        int n = m_bits.size();
        for (int i = 0; i < n && i < FB; i++) f[i] = m_bits[n-1-i];
        return f;
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_cnt = 0; m_synced = 0; m_prev_ck = 0; m_prev_lt = 0;
        m_data = '0; m_valid = 0; m_error = 0; m_count = 0;
    endtask

    task automatic cycle(input bit r, input bit e, input bit s, input bit ck, input bit lt);
        bit crise, lrise;
        @(negedge clk);
        reset = r; en = e; link.serial_in = s; link.ext_clk = ck; link.ext_latch = lt;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            crise = ck && !m_prev_ck;
            lrise = lt && !m_prev_lt;
            m_prev_ck = ck; m_prev_lt = lt;
            m_valid = 0;
            if (e) begin
                if (crise) begin
                    m_bits.push_back(s);
                    if (m_bits.size() > FB) void'(m_bits.pop_front());
                    m_cnt = (m_cnt < 63) ? m_cnt + 1 : 63;
                end
                if (lrise) begin
                    if (!m_synced) begin
                        m_bits.delete(); m_cnt = 0; m_synced = 1;
                    end else begin
                        m_data  = model_frame();
                        m_error = (m_cnt != FB);
                        m_valid = 1;
                        m_count = (m_count + 1) % 256;
                        m_cnt   = 0;
                    end
                end
            end
        end
        #1;
        if (frame_valid) valid_seen++;
        chk_eq("frame_valid", 64'(frame_valid), 64'(m_valid));
        chk_eq("frame_data",  64'(frame_data),  64'(m_data));
        chk_eq("frame_error", 64'(frame_error), 64'(m_error));
        chk_eq("frame_count", 64'(frame_count), 64'(m_count));
        chk_eq("synced",      64'(synced),      64'(m_synced));
    endtask

    task automatic send_bit(input bit b, input bit e);
        cycle(0, e, b, 1, 0);
        cycle(0, e, 1'($urandom), 0, 0);
        if ($urandom_range(0, 3) == 0) cycle(0, e, 1'($urandom), 0, 0);
    endtask

    task automatic latch();
        cycle(0, 1, 1'($urandom), 0, 1);
        cycle(0, 1, 1'($urandom), 0, 0);
    endtask

    task automatic rand_bits(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom), 1);
    endtask

    initial begin
        logic [47:0] a5;
        a5 = 48'hA5A5A5A5A5A5;
        reset = 1; en = 0; link.serial_in = 0; link.ext_clk = 0; link.ext_latch = 0;
        model_reset();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 1, 1, 1, 1);
        chk_eq("reset_count", 64'(frame_count), 64'd0);

        // Junk before first latch: sync only, no publish.
        rand_bits(20);
        latch();
        chk_eq("sync_no_count", 64'(frame_count), 64'd0);
        chk_eq("sync_set", 64'(synced), 64'd1);

        // Good A5 frame, MSB of each byte first.
        for (int i = 47; i >= 0; i--) send_bit(a5[i], 1);
        cycle(0, 1, 0, 0, 1);
        chk_eq("a5_valid", 64'(frame_valid), 64'd1);
        chk_eq("a5_data", 64'(frame_data), 64'hA5A5A5A5A5A5);
        chk_eq("a5_error", 64'(frame_error), 64'd0);
        chk_eq("a5_count", 64'(frame_count), 64'd1);
        cycle(0, 1, 0, 0, 1);
        chk_eq("latch_held_no_pulse", 64'(frame_valid), 64'd0);
        cycle(0, 1, 0, 0, 0);

        // Short then good frame.
        rand_bits(47); latch();
        chk_eq("short_error", 64'(frame_error), 64'd1);
        rand_bits(48); latch();
        chk_eq("good_clears_error", 64'(frame_error), 64'd0);

        // Long frame keeps last 48 bits.
        rand_bits(55); latch();
        chk_eq("long_error", 64'(frame_error), 64'd1);

        // 48th edge coincides with the latch edge.
        rand_bits(47);
        cycle(0, 1, 1, 1, 1);
        chk_eq("simul_valid", 64'(frame_valid), 64'd1);
        chk_eq("simul_error", 64'(frame_error), 64'd0);
        chk_eq("simul_lsb", 64'(frame_data[0]), 64'd1);
        cycle(0, 1, 0, 0, 0);

        // Gated pulses are ignored.
        rand_bits(20);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
        rand_bits(28); latch();
        chk_eq("gated_total_48", 64'(frame_error), 64'd0);
        rand_bits(20);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom), 0);
        rand_bits(18); latch();
        chk_eq("gated_short", 64'(frame_error), 64'd1);

        // Reset mid-frame, then the next latch only resyncs.
        rand_bits(17);
        cycle(1, 1, 0, 1, 0);
        chk_eq("midreset_data", 64'(frame_data), 64'd0);
        chk_eq("midreset_synced", 64'(synced), 64'd0);
        cycle(0, 1, 0, 0, 0);
        rand_bits(48); latch();
        chk_eq("after_reset_no_pub", 64'(frame_count), 64'd0);

        // 256 good frames wrap the counter.
        valid_seen = 0;
        for (int f = 0; f < 256; f++) begin
            rand_bits(48); latch();
        end
        chk_eq("valid_256", 64'(valid_seen), 64'd256);
        chk_eq("count_wrap", 64'(frame_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
